comparador_histeresis: RTL and testbench
========================================

# comparador_histeresis

Registered successor of the combinational sample-versus-moving-average comparator in the oversampled detection path. Compares the current accumulated sample against the moving average with a programmable hysteresis band and a minimum-run (debounce) qualifier, and drives a clean binary decision with a valid strobe and optional edge pulses. It sits between the moving-average filter and the downstream symbol/event logic.

## Interface
- SAMPLES, 128, moving-average window length.
- OSF, 8, oversampling factor.
- MIN_RUN, 3, consecutive qualifying valid samples required before DataOut toggles (≥1).
- Derived W = $clog2(SAMPLES*OSF)+1 (data width, unsigned); CW = $clog2(MIN_RUN+1).
- Clk  in  1  rising-edge clock, single clock domain.
- Reset  in  1  synchronous, active-high reset.
- Enable  in  1  block enable; low forces decision to 0.
- Valid  in  1  sample strobe; DataIn1/DataIn2 are sampled only when high.
- DataIn1  in  W  current sample.
- DataIn2  in  W  moving average.
- Hyst  in  W  hysteresis half-band, quasi-static.
- DataOut  out  1  registered decision.
- ValidOut  out  1  one-cycle strobe: a sample was evaluated.
- RiseEdge  out  1  one-cycle pulse on DataOut 0→1.
- FallEdge  out  1  one-cycle pulse on DataOut 1→0.

## Operation
- States: LOW, RISING, HIGH, FALLING; counter cnt (CW bits).
- All comparisons in W+1 bits, no wrap: rise_cond = DataIn1 ≥ DataIn2 + Hyst; fall_cond = DataIn1 + Hyst < DataIn2.
- LOW: on Valid & rise_cond → RISING, cnt=1 (if MIN_RUN=1 go directly to HIGH).
- RISING: Valid & rise_cond → cnt+1; reaching MIN_RUN → HIGH, DataOut=1, RiseEdge. Valid & !rise_cond → LOW, cnt=0.
- HIGH/FALLING: mirror using fall_cond; reaching MIN_RUN → LOW, DataOut=0, FallEdge.
- Valid low: state, cnt, DataOut held; gaps do not break a run.
- Enable low: next edge forces LOW, cnt=0, DataOut=0, ValidOut=0; no edge pulse generated.
- Hyst=0, MIN_RUN=1: DataOut equals registered (DataIn1 ≥ DataIn2) & Enable — legacy behaviour.
- Saturation: DataIn2+Hyst > 2^W−1 → rise never fires; Hyst > DataIn2 → fall never fires.

## Timing
- Reset values: state LOW, cnt 0, DataOut 0, ValidOut 0, RiseEdge 0, FallEdge 0.
- Latency: sample accepted at edge N → ValidOut high in cycle N+1; DataOut/edge pulses change in cycle N+1 when that sample completes a run.
- RiseEdge/FallEdge coincide with the first cycle of the new DataOut value, exactly one cycle wide.
- Reset has priority over Enable; Enable has priority over Valid.
- Reset mid-run: run discarded, outputs to reset values next cycle.
- Back-to-back Valid every cycle supported; throughput one sample/cycle.

## Configuration
- COMPARADOR_EDGE_EN defined: RiseEdge/FallEdge generated as above.
- Not defined: edge logic removed, RiseEdge and FallEdge tied to 0; DataOut/ValidOut behaviour unchanged.

## Structure
- Package comparador_pkg: state enum (LOW, RISING, HIGH, FALLING), width helper function for W and CW.
- One sub-module: contador_racha — run counter with clear, increment-on-qualify, terminal-count flag at MIN_RUN.

## Test plan
(SAMPLES=128, OSF=8 → W=11; MIN_RUN=3; Hyst=4.)
- Reset 2 cycles, then idle → DataOut=0, ValidOut=0, RiseEdge=FallEdge=0.
- DataIn2=500, DataIn1=503 ×5 valid → DataOut stays 0; then 504 ×3 → DataOut=1 one cycle after third, RiseEdge pulse 1 cycle.
- In LOW: 504,504,300,504,504 → no toggle; 504 once more → DataOut=1.
- In HIGH, DataIn2=500: 496 ×5 → stays 1; 495 ×3 with Valid low gaps between → DataOut=0, FallEdge pulse.
- DataIn2=2045, DataIn1=2047 ×10 → DataOut stays 0; in HIGH, DataIn2=2, DataIn1=0 ×10 → DataOut stays 1.
- DataOut=1, Enable dropped one cycle → DataOut=0 next cycle, FallEdge=0, ValidOut=0; Reset asserted during RISING → run discarded, needs 3 fresh samples.

Source files
------------

// File: rtl/comparador_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : comparador_pkg
//  Description : Shared types and width helpers for the hysteresis comparator
//                (decision state encoding, data and run-counter widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package comparador_pkg;

   // Decision state: settled LOW/HIGH, or accumulating a run towards the other side
   typedef enum logic [1:0] {
      ST_LOW     = 2'd0,
      ST_RISING  = 2'd1,
      ST_HIGH    = 2'd2,
      ST_FALLING = 2'd3
   } state_t;

   // Data width able to hold the accumulated sum of SAMPLES*OSF, unsigned
   function automatic int calc_w(input int samples, input int osf);
      return $clog2(samples * osf) + 1;
   endfunction

   // Run counter width; never narrower than one bit
   function automatic int calc_cw(input int min_run);
      return (min_run < 1) ? 1 : $clog2(min_run + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/contador_racha.sv
`default_nettype none
// ============================================================================
//  Module      : contador_racha
//  Description : Run counter for the debounce qualifier. Clear has priority
//                over increment; 'last' flags that one more qualifying sample
//                completes a run of MIN_RUN.
//  Revision    : 1.0 - initial release
// ============================================================================
module contador_racha #(
   parameter int MIN_RUN = 3,
   parameter int CW      = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic last
);

   localparam logic [CW-1:0] C_LAST = CW'(MIN_RUN - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins, otherwise count qualifying samples
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Count register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/comparador_histeresis.sv
`default_nettype none
// ============================================================================
//  Module      : comparador_histeresis
//  Description : Registered sample-vs-moving-average comparator with
//                programmable hysteresis band and minimum-run debounce.
//                Optional edge pulses enabled by defining COMPARADOR_EDGE_EN;
//                without it RiseEdge/FallEdge are tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module comparador_histeresis
   import comparador_pkg::*;
#(
   parameter int SAMPLES = 128,
   parameter int OSF     = 8,
   parameter int MIN_RUN = 3,
   localparam int W      = calc_w(SAMPLES, OSF),
   localparam int CW     = calc_cw(MIN_RUN)
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Enable,
   input  logic         Valid,
   input  logic [W-1:0] DataIn1,
   input  logic [W-1:0] DataIn2,
   input  logic [W-1:0] Hyst,
   output logic         DataOut,
   output logic         ValidOut,
   output logic         RiseEdge,
   output logic         FallEdge
);

   state_t state_q, state_d;
   logic   dout_q,  dout_d;
   logic   vout_q,  vout_d;
   logic   rise_d,  fall_d;
   logic   cnt_clr, cnt_inc, cnt_last;
   logic   rise_cond, fall_cond;

   // Comparisons carried in W+1 bits so the hysteresis sum can never wrap
   assign rise_cond = {1'b0, DataIn1} >= ({1'b0, DataIn2} + {1'b0, Hyst});
   assign fall_cond = ({1'b0, DataIn1} + {1'b0, Hyst}) < {1'b0, DataIn2};

   contador_racha #(
      .MIN_RUN (MIN_RUN),
      .CW      (CW)
   ) u_racha (
      .clk  (Clk),
      .rst  (Reset),
      .clr  (cnt_clr),
      .inc  (cnt_inc),
      .last (cnt_last)
   );

   // Next-state/output decision: Enable overrides Valid; a broken run restarts
   always_comb begin
      state_d = state_q;
      dout_d  = dout_q;
      vout_d  = 1'b0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      if (!Enable) begin
         state_d = ST_LOW;
         dout_d  = 1'b0;
         cnt_clr = 1'b1;
      end else if (Valid) begin
         vout_d = 1'b1;
         case (state_q)
            ST_LOW, ST_RISING: begin
               if (rise_cond) begin
                  if (cnt_last) begin
                     state_d = ST_HIGH;
                     dout_d  = 1'b1;
                     rise_d  = 1'b1;
                     cnt_clr = 1'b1;
                  end else begin
                     state_d = ST_RISING;
                     cnt_inc = 1'b1;
                  end
               end else begin
                  state_d = ST_LOW;
                  cnt_clr = 1'b1;
               end
            end
            ST_HIGH, ST_FALLING: begin
               if (fall_cond) begin
                  if (cnt_last) begin
                     state_d = ST_LOW;
                     dout_d  = 1'b0;
                     fall_d  = 1'b1;
                     cnt_clr = 1'b1;
                  end else begin
                     state_d = ST_FALLING;
                     cnt_inc = 1'b1;
                  end
               end else begin
                  state_d = ST_HIGH;
                  cnt_clr = 1'b1;
               end
            end
            default: begin
               state_d = ST_LOW;
               dout_d  = 1'b0;
               cnt_clr = 1'b1;
            end
         endcase
      end
   end

   // State and registered outputs
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_LOW;
         dout_q  <= 1'b0;
         vout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dout_q  <= dout_d;
         vout_q  <= vout_d;
      end
   end

   assign DataOut  = dout_q;
   assign ValidOut = vout_q;

`ifdef COMPARADOR_EDGE_EN
   logic rise_q, fall_q;

   // One-cycle edge pulses aligned with the first cycle of the new decision
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign RiseEdge = rise_q;
   assign FallEdge = fall_q;
`else
   logic edge_unused;
   assign edge_unused = rise_d ^ fall_d;
   assign RiseEdge    = 1'b0;
   assign FallEdge    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_comparador_histeresis.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comparador_histeresis
//  Description : Self-checking bench: directed scenarios plus randomized
//                traffic, expected outputs queued per cycle by a behavioural
//                model and compared by an independent monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_comparador_histeresis;

   localparam int SAMPLES = 128;
   localparam int OSF     = 8;
   localparam int MIN_RUN = 3;
   localparam int W       = 11;
   localparam int MAXV    = (1 << W) - 1;
`ifdef COMPARADOR_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   logic         Clk = 1'b0;
   logic         Reset = 1'b1;
   logic         Enable = 1'b0;
   logic         Valid = 1'b0;
   logic [W-1:0] DataIn1 = '0;
   logic [W-1:0] DataIn2 = '0;
   logic [W-1:0] Hyst = '0;
   logic         DataOut, ValidOut, RiseEdge, FallEdge;

   comparador_histeresis #(
      .SAMPLES (SAMPLES),
      .OSF     (OSF),
      .MIN_RUN (MIN_RUN)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Enable   (Enable),
      .Valid    (Valid),
      .DataIn1  (DataIn1),
      .DataIn2  (DataIn2),
      .Hyst     (Hyst),
      .DataOut  (DataOut),
      .ValidOut (ValidOut),
      .RiseEdge (RiseEdge),
      .FallEdge (FallEdge)
   );

   always #5 Clk = ~Clk;

   // Expected {DataOut, ValidOut, RiseEdge, FallEdge} for the cycle after each stimulus
   logic [3:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   // Reference model: current decision and length of the ongoing qualifying run
   bit m_dec = 1'b0;
   int m_run = 0;

   task automatic step(input bit rst, input bit en, input bit v,
                       input int d1, input int d2, input int h);
      bit vo, re, fe, qual;
      @(negedge Clk);
      Reset   = rst;
      Enable  = en;
      Valid   = v;
      DataIn1 = W'(d1);
      DataIn2 = W'(d2);
      Hyst    = W'(h);
      vo = 1'b0; re = 1'b0; fe = 1'b0;
      if (rst || !en) begin
         m_dec = 1'b0;
         m_run = 0;
      end else if (v) begin
         vo   = 1'b1;
         qual = m_dec ? ((d1 + h) < d2) : (d1 >= (d2 + h));
         if (qual) begin
            m_run++;
            if (m_run >= MIN_RUN) begin
               m_dec = !m_dec;
               m_run = 0;
               if (m_dec) re = 1'b1;
               else       fe = 1'b1;
            end
         end else begin
            m_run = 0;
         end
      end
      exp_q.push_back({m_dec, vo, re & EDGE_EN, fe & EDGE_EN});
   endtask

   task automatic burst(input int n, input int d1, input int d2, input int h);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, d1, d2, h);
   endtask

   // Monitor: one expected entry per cycle, sampled just after the active edge
   initial begin
      logic [3:0] got, exp;
      forever begin
         @(posedge Clk);
         #1;
         if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = {DataOut, ValidOut, RiseEdge, FallEdge};
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL outputs t=%0t {DataOut,ValidOut,RiseEdge,FallEdge} got %b expected %b",
                        $time, got, exp);
            end
         end
      end
   end

   initial begin
      int d1, d2, h;
      bit v, en, rst;

      // Reset then idle
      step(1'b1, 1'b0, 1'b0, 0, 0, 4);
      step(1'b1, 1'b0, 1'b0, 0, 0, 4);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 0, 0, 4);

      // Inside the band: no toggle; then a qualifying run of three
      burst(5, 503, 500, 4);
      burst(3, 504, 500, 4);
      step(1'b0, 1'b1, 1'b0, 504, 500, 4);

      // Return to LOW, then interrupted run
      burst(3, 495, 500, 4);
      burst(2, 504, 500, 4);
      burst(1, 300, 500, 4);
      burst(2, 504, 500, 4);
      burst(1, 504, 500, 4);

      // In HIGH: inside band holds; falling run with Valid gaps
      burst(5, 496, 500, 4);
      for (int i = 0; i < 3; i++) begin
         burst(1, 495, 500, 4);
         step(1'b0, 1'b1, 1'b0, 0, 500, 4);
      end

      // Saturation: rise never fires near the top of range
      burst(10, 2047, 2045, 4);
      burst(3, 504, 500, 4);
      // Saturation: fall never fires when Hyst exceeds the average
      burst(10, 0, 2, 4);

      // Enable drop while HIGH: decision cleared, no edge, no ValidOut
      step(1'b0, 1'b0, 1'b1, 504, 500, 4);
      step(1'b0, 1'b1, 1'b0, 504, 500, 4);

      // Reset mid-run discards it; three fresh samples required
      burst(2, 504, 500, 4);
      step(1'b1, 1'b1, 1'b1, 504, 500, 4);
      burst(2, 504, 500, 4);
      burst(1, 504, 500, 4);
      step(1'b0, 1'b1, 1'b0, 504, 500, 4);

      // Legacy-like behaviour with zero hysteresis
      burst(4, 500, 500, 0);
      burst(4, 499, 500, 0);

      // Randomized traffic around the average, with gaps, disables and resets
      for (int i = 0; i < 3000; i++) begin
         h   = int'($urandom_range(0, 12));
         d2  = int'($urandom_range(0, MAXV));
         d1  = d2 + int'($urandom_range(0, 40)) - 20;
         if (d1 < 0)    d1 = 0;
         if (d1 > MAXV) d1 = MAXV;
         v   = ($urandom_range(0, 3) != 0);
         en  = ($urandom_range(0, 49) != 0);
         rst = ($urandom_range(0, 199) == 0);
         step(rst, en, v, d1, d2, h);
      end

      step(1'b0, 1'b1, 1'b0, 0, 0, 0);
      @(posedge Clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending entries got %0d expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
